// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep evaluator.
package tt_sweep_pkg;
    // Widest function the evaluator is meant to be built for.
    localparam int MAX_N_IN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of input combinations for an n-input function.
    function automatic int depth_of(input int n);
        return 1 << n;
    endfunction
endpackage

// File: rtl/tt_index_counter.sv
// Input-vector counter for the sweep: clear, enable, saturates at the last index.
module tt_index_counter
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    output logic [N_IN-1:0] cnt,
    output logic            last
);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(depth_of(N_IN) - 1);

    logic [N_IN-1:0] cnt_q;

    // Advance on each accepted beat; hold at the last index instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (en && !last)
            cnt_q <= cnt_q + N_IN'(1);
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_IDX);
endmodule

// File: rtl/tt_sweep_eval.sv
// Exhaustive evaluator: sweeps every input vector of a loaded truth table,
// streams (in_vec, s) beats, counts ones and optionally compares to an expected table.
module tt_sweep_eval
    import tt_sweep_pkg::*;
#(
    parameter  int N_IN  = 4,
    localparam int DEPTH = depth_of(N_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tt_load,
    input  logic [DEPTH-1:0] tt_data,
    input  logic [DEPTH-1:0] exp_data,
    input  logic             cmp_en,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N_IN-1:0]  in_vec,
    output logic             s,
    output logic             busy,
    output logic             done,
    output logic [N_IN:0]    ones_count,
    output logic [N_IN:0]    mismatch_count,
    output logic [N_IN-1:0]  first_mismatch,
    output logic             all_match
);
    state_t           state_q;
    logic [DEPTH-1:0] tt_q, exp_q;
    logic             cmp_q, all_q, done_q;
    logic [N_IN:0]    ones_q, ones_d, mis_q, mis_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic [N_IN-1:0]  cnt;
    logic             last, run, accept, cur_s, miss, go;

    assign run    = (state_q == RUN);
    assign go     = (state_q == IDLE) && start;
    assign accept = run && out_ready;
    assign cur_s  = tt_q[cnt];
    assign miss   = cmp_q && (cur_s != exp_q[cnt]);

    tt_index_counter #(.N_IN(N_IN)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (go),
        .en   (accept),
        .cnt  (cnt),
        .last (last)
    );

    // Accumulator next-state: cleared at start, updated per accepted beat.
    always_comb begin
        ones_d  = ones_q;
        mis_d   = mis_q;
        first_d = first_q;
        if (go) begin
            ones_d  = '0;
            mis_d   = '0;
            first_d = '0;
        end else if (accept) begin
            if (cur_s)
                ones_d = ones_q + (N_IN+1)'(1);
            if (miss) begin
                mis_d = mis_q + (N_IN+1)'(1);
                if (mis_q == '0)
                    first_d = cnt;
            end
        end
    end

    // Control FSM, table capture and registered status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tt_q    <= '0;
            exp_q   <= '0;
            cmp_q   <= 1'b0;
            ones_q  <= '0;
            mis_q   <= '0;
            first_q <= '0;
            all_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            mis_q   <= mis_d;
            first_q <= first_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Load lands on the same edge as start, so the sweep sees the new table.
                    if (tt_load) begin
                        tt_q  <= tt_data;
                        exp_q <= exp_data;
                    end
                    if (start) begin
                        cmp_q   <= cmp_en;
                        all_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept && last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        // Uses the final count including the last beat.
                        all_q   <= cmp_q && (mis_d == '0);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid      = run;
    assign busy           = run;
    assign in_vec         = run ? cnt : '0;
    assign s              = run && cur_s;
    assign done           = done_q;
    assign ones_count     = ones_q;
    assign mismatch_count = mis_q;
    assign first_mismatch = first_q;
    assign all_match      = all_q;
endmodule

// File: tb/tb_tt_sweep_eval.sv
// Scoreboard bench for tt_sweep_eval (N_IN=4): driver pushes expected beats and
// sweep results, a negedge monitor pops and compares them.
module tb_tt_sweep_eval;
    logic        clk = 1'b0, rst = 1'b1;
    logic        tt_load = 1'b0, cmp_en = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [15:0] tt_data = '0, exp_data = '0;
    logic        out_valid, s, busy, done, all_match;
    logic [3:0]  in_vec, first_mismatch;
    logic [4:0]  ones_count, mismatch_count;

    int total = 0, bad = 0;

    typedef struct {
        int   ones;
        int   mis;
        int   first;
        logic all_m;
    } res_t;

    res_t       res_q[$];
    logic [4:0] beat_q[$];

    tt_sweep_eval #(.N_IN(4)) dut (
        .clk(clk), .rst(rst), .tt_load(tt_load), .tt_data(tt_data), .exp_data(exp_data),
        .cmp_en(cmp_en), .start(start), .out_ready(out_ready), .out_valid(out_valid),
        .in_vec(in_vec), .s(s), .busy(busy), .done(done), .ones_count(ones_count),
        .mismatch_count(mismatch_count), .first_mismatch(first_mismatch), .all_match(all_match)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: compare each accepted beat and each sweep result against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0)
                    chk("beat_unexpected", 1, 0);
                else begin
                    logic [4:0] e;
                    e = beat_q.pop_front();
                    chk("beat_vec", int'(in_vec), int'(e[4:1]));
                    chk("beat_s", int'(s), int'(e[0]));
                end
            end
            if (done) begin
                if (res_q.size() == 0)
                    chk("done_unexpected", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("ones_count", int'(ones_count), r.ones);
                    chk("mismatch_count", int'(mismatch_count), r.mis);
                    if (r.mis != 0)
                        chk("first_mismatch", int'(first_mismatch), r.first);
                    chk("all_match", int'(all_match), int'(r.all_m));
                end
            end
        end
    end

    // One sweep with load+start in the same cycle; optional stall and mid-sweep poke.
    task automatic sweep(input logic [15:0] tt, input logic [15:0] ex, input logic cmp,
                         input int stall_at, input int poke_at,
                         input int e_ones, input int e_mis, input int e_first,
                         input logic e_all, input int e_cyc);
        int   cyc;
        bit   stalled, poked;
        logic [4:0] hold_ones;
        res_t r;
        for (int i = 0; i < 16; i++) beat_q.push_back({4'(i), tt[i]});
        r.ones = e_ones; r.mis = e_mis; r.first = e_first; r.all_m = e_all;
        res_q.push_back(r);
        @(posedge clk); #1;
        tt_data = tt; exp_data = ex; cmp_en = cmp; tt_load = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        tt_load = 1'b0; start = 1'b0; cmp_en = ~cmp;
        cyc = 0; stalled = 0; poked = 0;
        while (!done && cyc < 200) begin
            if (busy && int'(in_vec) == stall_at && !stalled) begin
                out_ready = 1'b0;
                hold_ones = ones_count;
                repeat (3) begin
                    @(posedge clk); #1; cyc++;
                    chk("stall_vec", int'(in_vec), stall_at);
                    chk("stall_s", int'(s), int'(tt[stall_at]));
                    chk("stall_ones", int'(ones_count), int'(hold_ones));
                end
                out_ready = 1'b1;
                stalled = 1;
            end
            if (busy && int'(in_vec) == poke_at && !poked) begin
                tt_data = 16'hFFFF; exp_data = ~ex; tt_load = 1'b1; start = 1'b1;
                poked = 1;
            end
            @(posedge clk); #1; cyc++;
            tt_load = 1'b0; start = 1'b0;
        end
        chk("sweep_cycles", cyc, e_cyc);
        @(posedge clk); #1;
        chk("back_idle", int'({busy, done, out_valid}), 0);
    endtask

    // Abort a sweep at beat 7 with reset and confirm it dies silently.
    task automatic reset_mid();
        int cyc, dones;
        for (int i = 0; i < 16; i++) beat_q.push_back({4'(i), 1'b0});
        @(posedge clk); #1;
        tt_data = 16'h0000; exp_data = '0; cmp_en = 1'b0; tt_load = 1'b1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        tt_load = 1'b0; start = 1'b0;
        cyc = 0;
        while (!(busy && in_vec == 4'd7) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        chk("reach_beat7", int'(in_vec), 7);
        rst = 1'b1;
        beat_q.delete();
        #1;
        chk("rst_mid_outputs", int'({out_valid, in_vec, s, busy, done, ones_count,
                                     mismatch_count, first_mismatch, all_match}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("no_done_after_rst", dones, 0);
    endtask

    initial begin
        #2;
        chk("reset_outputs", int'({out_valid, in_vec, s, busy, done, ones_count,
                                   mismatch_count, first_mismatch, all_match}), 0);
        #10 rst = 1'b0;
        reset_mid();
        // single one at the top index
        sweep(16'h8000, 16'h0000, 1'b0, -1, -1, 1, 0, 0, 1'b0, 16);
        // all ones: count reaches 16 without overflow
        sweep(16'hFFFF, 16'h0000, 1'b0, -1, -1, 16, 0, 0, 1'b0, 16);
        // compare mode, one mismatch at index 0
        sweep(16'h00FF, 16'h00FE, 1'b1, -1, -1, 8, 1, 0, 1'b0, 16);
        // compare mode, exact match
        sweep(16'h00FF, 16'h00FF, 1'b1, -1, -1, 8, 0, 0, 1'b1, 16);
        // two mismatches (bits 5 and 10): first stays at 5
        sweep(16'h0C30, 16'h0810, 1'b1, -1, -1, 4, 2, 5, 1'b0, 16);
        // backpressure at in_vec=5 for 3 cycles
        sweep(16'hA5C3, 16'h0000, 1'b0, 5, -1, 8, 0, 0, 1'b0, 19);
        // start/tt_load poked mid-sweep must be ignored
        sweep(16'h0F0F, 16'h0F0F, 1'b0, -1, 4, 8, 0, 0, 1'b0, 16);
        // same-cycle load+start picks up the freshly loaded table
        sweep(16'h0001, 16'h0001, 1'b1, -1, -1, 1, 0, 0, 1'b1, 16);
        chk("beat_queue_empty", beat_q.size(), 0);
        chk("result_queue_empty", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
